// File: rtl/viterbi_pkg.sv
// Shared types and widths for the Viterbi BER checker.
package viterbi_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bit_fifo.sv
// Single-bit FIFO for reference bits; pop may remove up to two entries per cycle.
module bit_fifo #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          din,
  input  logic [1:0]    pop,
  output logic          dout,
  output logic          dout_nxt,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_nxt;

  assign rd_nxt   = rd_ptr + 1'b1;
  assign dout     = mem[rd_ptr];
  assign dout_nxt = mem[rd_nxt];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/viterbi_ber_checker.sv
// Aligns decoder output against queued reference bits, locks, and measures bit errors per window.
module viterbi_ber_checker
  import viterbi_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int LOCK_THR = 16,
  parameter int WIN      = 256,
  parameter int LOSS_THR = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_bit_i,
  input  logic             ref_valid_i,
  input  logic             dec_bit_i,
  input  logic             dec_valid_i,
  output logic             locked_o,
  output logic             bit_err_o,
  output logic [CNT_W-1:0] bit_ct_o,
  output logic [CNT_W-1:0] err_ct_o,
  output logic             win_done_o,
  output logic [CNT_W-1:0] win_errs_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(LOCK_THR + 1);
  localparam int WW = $clog2(WIN) + 1;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_dout;
  logic             fifo_dout_nxt;
  logic [1:0]       pop_n;
  logic             push;
  logic             compare;
  logic             two_avail;
  logic             ref_sel;
  logic             mismatch;
  logic             slip_pend;
  logic             lock_hit;
  logic             win_end;
  logic             loss;
  logic [RW-1:0]    run_ct;
  logic [RW-1:0]    run_inc;
  logic [WW-1:0]    win_bits;
  logic [WW-1:0]    win_bits_inc;
  logic [CNT_W-1:0] win_errs;
  logic [CNT_W-1:0] win_errs_inc;

  bit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (ref_bit_i),
    .pop      (pop_n),
    .dout     (fifo_dout),
    .dout_nxt (fifo_dout_nxt),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // A pending slip drops the head first, so the compare already sees the shifted alignment
  assign compare   = dec_valid_i && !fifo_empty;
  assign two_avail = (fifo_count >= CW'(2));
  assign ref_sel   = (slip_pend && two_avail) ? fifo_dout_nxt : fifo_dout;
  assign mismatch  = compare && (ref_sel != dec_bit_i);
  assign pop_n     = compare ? ((slip_pend && two_avail) ? 2'd2 : 2'd1)
                             : ((slip_pend && !fifo_empty) ? 2'd1 : 2'd0);
  assign push      = ref_valid_i && (!fifo_full || (pop_n != 2'd0));

  assign run_inc      = run_ct + 1'b1;
  assign win_bits_inc = win_bits + 1'b1;
  assign win_errs_inc = win_errs + CNT_W'(mismatch);
  assign lock_hit     = (state == SEARCH) && compare && !mismatch && (run_inc == RW'(LOCK_THR));
  assign win_end      = (state == LOCKED) && compare && (win_bits_inc == WW'(WIN));
  assign loss         = win_end && (win_errs_inc > CNT_W'(LOSS_THR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SEARCH:  if (lock_hit) state_next = LOCKED;
      LOCKED:  if (loss) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  // All outputs are registered here, giving a fixed one-cycle compare-to-output latency
  always_ff @(posedge clk) begin
    if (rst) begin
      slip_pend  <= 1'b0;
      run_ct     <= '0;
      win_bits   <= '0;
      win_errs   <= '0;
      locked_o   <= 1'b0;
      bit_err_o  <= 1'b0;
      bit_ct_o   <= '0;
      err_ct_o   <= '0;
      win_done_o <= 1'b0;
      win_errs_o <= '0;
      ovf_o      <= 1'b0;
      unf_o      <= 1'b0;
    end else begin
      bit_err_o  <= 1'b0;
      win_done_o <= 1'b0;
      locked_o   <= (state_next == LOCKED);
      slip_pend  <= (state == SEARCH) && mismatch;
      if (ref_valid_i && !push) begin
        ovf_o <= 1'b1;
      end
      if (dec_valid_i && fifo_empty) begin
        unf_o <= 1'b1;
      end
      if (compare) begin
        if (state == SEARCH) begin
          run_ct <= (mismatch || lock_hit) ? '0 : run_inc;
          if (lock_hit) begin
            win_bits <= '0;
            win_errs <= '0;
          end
        end else begin
          bit_ct_o <= sat_inc(bit_ct_o);
          if (mismatch) begin
            err_ct_o  <= sat_inc(err_ct_o);
            bit_err_o <= 1'b1;
          end
          if (win_end) begin
            win_done_o <= 1'b1;
            win_errs_o <= win_errs_inc;
            win_bits   <= '0;
            win_errs   <= '0;
          end else begin
            win_bits <= win_bits_inc;
            win_errs <= win_errs_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Randomised bench for viterbi_ber_checker; a queue-based reference model predicts every output each cycle.
module tb_viterbi_ber_checker;

  localparam int DEPTH    = 64;
  localparam int LOCK_THR = 16;
  localparam int WIN      = 256;
  localparam int LOSS_THR = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        ref_bit_i, ref_valid_i, dec_bit_i, dec_valid_i;
  logic        locked_o, bit_err_o, win_done_o, ovf_o, unf_o;
  logic [15:0] bit_ct_o, err_ct_o, win_errs_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  viterbi_ber_checker #(
    .DEPTH(DEPTH), .LOCK_THR(LOCK_THR), .WIN(WIN), .LOSS_THR(LOSS_THR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ref_bit_i   (ref_bit_i),
    .ref_valid_i (ref_valid_i),
    .dec_bit_i   (dec_bit_i),
    .dec_valid_i (dec_valid_i),
    .locked_o    (locked_o),
    .bit_err_o   (bit_err_o),
    .bit_ct_o    (bit_ct_o),
    .err_ct_o    (err_ct_o),
    .win_done_o  (win_done_o),
    .win_errs_o  (win_errs_o),
    .ovf_o       (ovf_o),
    .unf_o       (unf_o)
  );

  // Reference model: queued ref bits plus the expected value of every output
  bit mq[$];
  bit m_slip;
  int m_run, m_wbits, m_werrs;
  bit e_locked, e_bit_err, e_win_done, e_ovf, e_unf;
  int e_bit_ct, e_err_ct, e_win_errs;
  bit rs[$];
  bit ds[$];

  task automatic model_reset();
    mq.delete();
    m_slip = 0; m_run = 0; m_wbits = 0; m_werrs = 0;
    e_locked = 0; e_bit_err = 0; e_win_done = 0; e_ovf = 0; e_unf = 0;
    e_bit_ct = 0; e_err_ct = 0; e_win_errs = 0;
  endtask

  task automatic model_step(input bit rv, input bit rb, input bit dv, input bit db);
    int n0, removed;
    bit cmp, head, junk, mis;
    n0 = mq.size(); removed = 0; head = 0; mis = 0;
    cmp = dv && (n0 > 0);
    e_bit_err = 0; e_win_done = 0;
    if (dv && n0 == 0) e_unf = 1;
    if (cmp) begin
      if (m_slip && n0 >= 2) begin junk = mq.pop_front(); removed = 1; end
      head = mq.pop_front(); removed++;
      mis = (head != db);
    end else if (m_slip && n0 > 0) begin
      junk = mq.pop_front(); removed = 1;
    end
    m_slip = 0;
    if (rv) begin
      if (n0 < DEPTH || removed > 0) mq.push_back(rb);
      else e_ovf = 1;
    end
    if (cmp && !e_locked) begin
      if (mis) begin
        m_run = 0; m_slip = 1;
      end else begin
        m_run++;
        if (m_run == LOCK_THR) begin
          e_locked = 1; m_run = 0; m_wbits = 0; m_werrs = 0;
        end
      end
    end else if (cmp) begin
      if (e_bit_ct < 65535) e_bit_ct++;
      if (mis) begin
        e_bit_err = 1; m_werrs++;
        if (e_err_ct < 65535) e_err_ct++;
      end
      m_wbits++;
      if (m_wbits == WIN) begin
        e_win_done = 1; e_win_errs = m_werrs;
        if (m_werrs > LOSS_THR) e_locked = 0;
        m_wbits = 0; m_werrs = 0;
      end
    end
  endtask

  task automatic drive(input bit rv, input bit rb, input bit dv, input bit db);
    ref_valid_i = rv; ref_bit_i = rb; dec_valid_i = dv; dec_bit_i = db;
    model_step(rv, rb, dv, db);
    @(negedge clk);
  endtask

  task automatic stream_drive(input int t, input int d);
    bit rv, rb, dv, db;
    rv = (t < rs.size());
    rb = rv ? rs[t] : 1'b0;
    dv = (t >= d) && (t - d < ds.size());
    db = dv ? ds[t-d] : 1'b0;
    drive(rv, rb, dv, db);
  endtask

  task automatic make_stream(input int n);
    bit b;
    rs.delete(); ds.delete();
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      rs.push_back(b); ds.push_back(b);
    end
  endtask

  task automatic do_reset();
    rst = 1; ref_valid_i = 0; ref_bit_i = 0; dec_valid_i = 0; dec_bit_i = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  function automatic string got_str();
    return $sformatf("lock=%b err=%b wd=%b bc=%0d ec=%0d we=%0d ovf=%b unf=%b",
                     locked_o, bit_err_o, win_done_o, bit_ct_o, err_ct_o, win_errs_o, ovf_o, unf_o);
  endfunction

  function automatic string exp_str();
    return $sformatf("lock=%b err=%b wd=%b bc=%0d ec=%0d we=%0d ovf=%b unf=%b",
                     e_locked, e_bit_err, e_win_done, e_bit_ct, e_err_ct, e_win_errs, e_ovf, e_unf);
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if ({locked_o, bit_err_o, win_done_o, ovf_o, unf_o, bit_ct_o, err_ct_o, win_errs_o} !== 53'd0) begin
      failures++; $display("[TB] FAIL reset_outputs: got %s want all zero", got_str());
    end
  endtask

  task automatic test_prbs_lock();
    int first_lock, wd_ct;
    do_reset(); make_stream(500); first_lock = -1; wd_ct = 0;
    for (int t = 0; t < 512; t++) begin
      stream_drive(t, 10);
      checks++;
      if ({locked_o, bit_err_o, win_done_o, ovf_o, unf_o, bit_ct_o, err_ct_o, win_errs_o} !==
          {e_locked, e_bit_err, e_win_done, e_ovf, e_unf, 16'(e_bit_ct), 16'(e_err_ct), 16'(e_win_errs)}) begin
        failures++; $display("[TB] FAIL prbs t=%0d got %s want %s", t, got_str(), exp_str());
      end
      if (locked_o === 1'b1 && first_lock < 0) first_lock = t;
      if (win_done_o === 1'b1) begin
        wd_ct++; checks++;
        if (win_errs_o !== 16'd0) begin
          failures++; $display("[TB] FAIL prbs_win_errs: got %0d want 0", win_errs_o);
        end
      end
    end
    checks++;
    if (first_lock != 10 + LOCK_THR - 1) begin
      failures++; $display("[TB] FAIL prbs_lock_time: got %0d want %0d", first_lock, 10 + LOCK_THR - 1);
    end
    checks++;
    if (wd_ct != 1 || err_ct_o !== 16'd0 || bit_ct_o !== 16'(500 - LOCK_THR)) begin
      failures++; $display("[TB] FAIL prbs_totals: got wd=%0d ec=%0d bc=%0d want 1 0 %0d",
                           wd_ct, err_ct_o, bit_ct_o, 500 - LOCK_THR);
    end
  endtask

  task automatic test_bit_errors();
    int pulses;
    do_reset(); make_stream(300); pulses = 0;
    ds[100] = ~ds[100]; ds[101] = ~ds[101];
    for (int t = 0; t < 305; t++) begin
      stream_drive(t, 3);
      checks++;
      if ({locked_o, bit_err_o, win_done_o, ovf_o, unf_o, bit_ct_o, err_ct_o, win_errs_o} !==
          {e_locked, e_bit_err, e_win_done, e_ovf, e_unf, 16'(e_bit_ct), 16'(e_err_ct), 16'(e_win_errs)}) begin
        failures++; $display("[TB] FAIL flip t=%0d got %s want %s", t, got_str(), exp_str());
      end
      if (bit_err_o === 1'b1) begin
        pulses++; checks++;
        if (t != 103 && t != 104) begin
          failures++; $display("[TB] FAIL flip_pulse_time: got pulse at %0d want 103 or 104", t);
        end
      end
    end
    checks++;
    if (pulses != 2 || err_ct_o !== 16'd2) begin
      failures++; $display("[TB] FAIL flip_totals: got pulses=%0d ec=%0d want 2 2", pulses, err_ct_o);
    end
  endtask

  task automatic test_slip();
    int first_lock;
    do_reset(); make_stream(200); first_lock = -1;
    rs.push_front(~ds[0]);
    for (int t = 0; t < 208; t++) begin
      stream_drive(t, 5);
      checks++;
      if ({locked_o, bit_err_o, win_done_o, ovf_o, unf_o, bit_ct_o, err_ct_o, win_errs_o} !==
          {e_locked, e_bit_err, e_win_done, e_ovf, e_unf, 16'(e_bit_ct), 16'(e_err_ct), 16'(e_win_errs)}) begin
        failures++; $display("[TB] FAIL slip t=%0d got %s want %s", t, got_str(), exp_str());
      end
      if (locked_o === 1'b1 && first_lock < 0) first_lock = t;
    end
    checks++;
    if (first_lock != 5 + LOCK_THR || locked_o !== 1'b1 || err_ct_o !== 16'd0) begin
      failures++; $display("[TB] FAIL slip_lock: got t=%0d lock=%b ec=%0d want t=%0d 1 0",
                           first_lock, locked_o, err_ct_o, 5 + LOCK_THR);
    end
  endtask

  task automatic test_window_loss();
    int wd_t;
    do_reset(); make_stream(320); wd_t = -1;
    for (int i = 40; i < 80; i++) ds[i] = ~ds[i];
    for (int t = 0; t < 326; t++) begin
      stream_drive(t, 4);
      checks++;
      if ({locked_o, bit_err_o, win_done_o, ovf_o, unf_o, bit_ct_o, err_ct_o, win_errs_o} !==
          {e_locked, e_bit_err, e_win_done, e_ovf, e_unf, 16'(e_bit_ct), 16'(e_err_ct), 16'(e_win_errs)}) begin
        failures++; $display("[TB] FAIL loss t=%0d got %s want %s", t, got_str(), exp_str());
      end
      if (win_done_o === 1'b1 && wd_t < 0) begin
        wd_t = t; checks++;
        if (win_errs_o !== 16'd40 || locked_o !== 1'b0 || bit_ct_o !== 16'd256 || err_ct_o !== 16'd40) begin
          failures++; $display("[TB] FAIL loss_window: got we=%0d lock=%b bc=%0d ec=%0d want 40 0 256 40",
                               win_errs_o, locked_o, bit_ct_o, err_ct_o);
        end
      end
    end
    checks++;
    if (wd_t != 4 + LOCK_THR + WIN - 1 || locked_o !== 1'b1) begin
      failures++; $display("[TB] FAIL loss_relock: got wd_t=%0d lock=%b want %0d 1",
                           wd_t, locked_o, 4 + LOCK_THR + WIN - 1);
    end
  endtask

  task automatic test_ovf_unf();
    bit first;
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
    checks++;
    if (unf_o !== 1'b1 || bit_ct_o !== 16'd0 || ovf_o !== 1'b0) begin
      failures++; $display("[TB] FAIL unf_empty: got unf=%b bc=%0d ovf=%b want 1 0 0", unf_o, bit_ct_o, ovf_o);
    end
    do_reset();
    first = 1'($urandom_range(0, 1));
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, (i == 0) ? first : 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      checks++;
      if (ovf_o !== 1'b0) begin
        failures++; $display("[TB] FAIL ovf_fill i=%0d: got %b want 0", i, ovf_o);
      end
    end
    drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, first);
    checks++;
    if (ovf_o !== 1'b0 || unf_o !== 1'b0) begin
      failures++; $display("[TB] FAIL ovf_push_pop: got ovf=%b unf=%b want 0 0", ovf_o, unf_o);
    end
    drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    checks++;
    if (ovf_o !== 1'b1) begin
      failures++; $display("[TB] FAIL ovf_full: got %b want 1", ovf_o);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ovf_o !== 1'b1 || ovf_o !== e_ovf) begin
      failures++; $display("[TB] FAIL ovf_sticky: got %b want 1", ovf_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); make_stream(100);
    for (int t = 0; t < 40; t++) stream_drive(t, 20);
    checks++;
    if (locked_o !== 1'b1 || bit_ct_o !== 16'(40 - 20 - LOCK_THR)) begin
      failures++; $display("[TB] FAIL mid_prelock: got lock=%b bc=%0d want 1 %0d", locked_o, bit_ct_o, 40 - 20 - LOCK_THR);
    end
    rst = 1; ref_valid_i = 1; ref_bit_i = 1; dec_valid_i = 1; dec_bit_i = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
    checks++;
    if ({locked_o, bit_err_o, win_done_o, ovf_o, unf_o, bit_ct_o, err_ct_o, win_errs_o} !== 53'd0) begin
      failures++; $display("[TB] FAIL mid_reset_outputs: got %s want all zero", got_str());
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (unf_o !== 1'b1 || bit_ct_o !== 16'd0) begin
      failures++; $display("[TB] FAIL mid_fifo_empty: got unf=%b bc=%0d want 1 0", unf_o, bit_ct_o);
    end
    make_stream(60);
    for (int t = 0; t < 64; t++) begin
      stream_drive(t, 2);
      checks++;
      if ({locked_o, bit_err_o, win_done_o, ovf_o, unf_o, bit_ct_o, err_ct_o, win_errs_o} !==
          {e_locked, e_bit_err, e_win_done, e_ovf, e_unf, 16'(e_bit_ct), 16'(e_err_ct), 16'(e_win_errs)}) begin
        failures++; $display("[TB] FAIL mid_restream t=%0d got %s want %s", t, got_str(), exp_str());
      end
    end
  endtask

  initial begin
    rst = 1; ref_valid_i = 0; ref_bit_i = 0; dec_valid_i = 0; dec_bit_i = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_prbs_lock();
    test_bit_errors();
    test_slip();
    test_window_loss();
    test_ovf_unf();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/viterbi_ber_checker.md
VITERBI_BER_CHECKER -- requirements
Module: viterbi_ber_checker

Interface
REQ-001 Parameter DEPTH, default 64: reference-bit FIFO depth, power of two.
REQ-002 Parameter LOCK_THR, default 16: consecutive matches needed to declare lock.
REQ-003 Parameter WIN, default 256: compared bits per error window, power of two.
REQ-004 Parameter LOSS_THR, default 32: window error count above which lock is lost.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 ref_bit_i  input  1  transmitted (pre-encoder) data bit.
REQ-008 ref_valid_i  input  1  ref_bit_i is valid this cycle.
REQ-009 dec_bit_i  input  1  decoder output bit.
REQ-010 dec_valid_i  input  1  dec_bit_i is valid this cycle.
REQ-011 locked_o  output  1  checker is aligned (LOCKED state).
REQ-012 bit_err_o  output  1  one-cycle pulse: mismatch counted in LOCKED.
REQ-013 bit_ct_o  output  16  bits compared while LOCKED, saturating.
REQ-014 err_ct_o  output  16  mismatches while LOCKED, saturating.
REQ-015 win_done_o  output  1  one-cycle pulse at end of each WIN-bit window.
REQ-016 win_errs_o  output  16  error count of the last completed window.
REQ-017 ovf_o  output  1  sticky: ref bit dropped because FIFO was full.
REQ-018 unf_o  output  1  sticky: dec_valid_i arrived with FIFO empty.

Function
REQ-019 Push ref_bit_i into FIFO when ref_valid_i and FIFO not full, or full with a pop in the same cycle.
REQ-020 Full with ref_valid_i and no pop: drop bit, set ovf_o.
REQ-021 On dec_valid_i with FIFO non-empty: pop one ref bit, compare with dec_bit_i.
REQ-022 On dec_valid_i with FIFO empty: no compare, no state change, set unf_o.
REQ-023 FSM states: SEARCH, LOCKED; SEARCH after reset.
REQ-024 SEARCH: match increments run counter; run counter reaching LOCK_THR moves to LOCKED next cycle and clears run and window counters.
REQ-025 SEARCH mismatch: clear run counter and discard one additional FIFO entry next cycle (slip); no slip if FIFO empty.
REQ-026 Slip and pop in the same cycle remove two entries only if occupancy >= 2, else one.
REQ-027 LOCKED: each compare increments bit_ct_o and window bit count; mismatch increments err_ct_o and window errors, pulses bit_err_o the cycle after compare.
REQ-028 Counters saturate at 16'hFFFF; no wrap.
REQ-029 Window bit count reaching WIN: next cycle pulse win_done_o, load win_errs_o, clear window counters.
REQ-030 win_errs_o > LOSS_THR at window end: return to SEARCH same cycle as win_done_o; bit_ct_o/err_ct_o hold.
REQ-031 locked_o registered, asserted the cycle LOCKED is entered.
REQ-032 Compare-to-output latency: exactly one cycle for all outputs.

Reset
REQ-033 rst clears FIFO pointers, run/window counters, all outputs to 0, FSM to SEARCH.
REQ-034 rst mid-stream discards in-flight FIFO contents; first bit after rst deasserts is treated as new.
REQ-035 rst has priority over every simultaneous event.

Structure
REQ-036 Package viterbi_pkg holds the state enum (SEARCH, LOCKED) and 16-bit counter width constant.
REQ-037 FIFO is one sub-module, bit_fifo (DEPTH, push, pop, dout, full, empty, count).

Verification
REQ-038 Identical 500-bit PRBS on ref and dec, dec delayed 10 cycles -> locked_o after 16 compares, err_ct_o=0, win_done_o each 256 bits, win_errs_o=0.
REQ-039 Locked stream, flip dec bits at indices 100 and 101 -> two bit_err_o pulses, err_ct_o=2.
REQ-040 Extra leading ref bit (dec misaligned by 1) -> one slip, then lock after 16 matches.
REQ-041 Window with 40 forced errors -> win_errs_o=40, locked_o falls with win_done_o.
REQ-042 65 ref pushes, no pops -> ovf_o=1 after 65th; dec_valid_i with empty FIFO -> unf_o=1.
REQ-043 rst pulsed while LOCKED with 20 bits queued -> all outputs 0, FIFO empty next cycle.
